// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver: receive FSM state encoding,
// parity-mode constants, the default bit period and a parity-check helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_PUSH      = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 115200 baud at 73.728 MHz
    localparam int DEFAULT_CLKS_PER_BIT = 640;

    // data_xor is the XOR-reduction of the received data bits.
    // Odd mode expects the total XOR (data + parity bit) to be 1, even mode 0.
    function automatic logic parity_error(input logic data_xor,
                                          input logic par_bit,
                                          input int   mode);
        logic err;
        case (mode)
            PAR_ODD:  err = ~(data_xor ^ par_bit);
            PAR_EVEN: err = data_xor ^ par_bit;
            default:  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
// First-word-fall-through FIFO. The head word is presented on data_o whenever
// the FIFO is non-empty (and forced to zero when empty).
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, data_i  : write request and word; ignored when full unless a pop
//                     happens in the same cycle
//   pop_i           : remove head word; ignored when empty
//   data_o          : head word
//   full_o, empty_o : occupancy flags
//   count_o         : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

    // A push into a full FIFO still succeeds when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    assign wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; a slot is never read before it is
    // written, and the empty gating below keeps data_o at zero until then.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver with a receive FIFO. Frames are start + DATA_BITS (LSB first)
// + optional parity + STOP_BITS. Each frame is stored as
// {frame_err, parity_err, data}.
//   in_clk, in_reset   : clock, asynchronous active-low reset
//   rx_serial          : asynchronous serial input, idle high
//   out_data           : head word data
//   out_parity_err     : head word parity error
//   out_frame_err      : head word framing error
//   out_valid          : FIFO not empty
//   in_ready           : pop head when out_valid is also high
//   out_count          : FIFO occupancy
//   out_overflow       : sticky, set when a word is dropped on a full FIFO
//   in_clear_overflow  : synchronous clear of out_overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         in_clk,
    input  logic                         in_reset,
    input  logic                         rx_serial,
    output logic [DATA_BITS-1:0]         out_data,
    output logic                         out_parity_err,
    output logic                         out_frame_err,
    output logic                         out_valid,
    input  logic                         in_ready,
    output logic [$clog2(FIFO_DEPTH):0]  out_count,
    output logic                         out_overflow,
    input  logic                         in_clear_overflow
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = 4;
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    // Synchroniser and edge detection
    logic [1:0] sync_q;
    logic [1:0] sync_vld_q;
    logic       rx_prev_q;
    logic       rx_sync;
    logic       fall;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 overflow_q, overflow_d;
    logic                 push;

    logic [WORD_W-1:0]    head_word;
    logic                 fifo_full, fifo_empty, pop;

    assign rx_sync = sync_q[1];

    // rx_prev_q only follows the line once the synchroniser holds genuine line
    // samples. Releasing reset while the line is low (mid-frame) therefore
    // cannot look like a falling edge; a real high-to-low transition is needed.
    assign fall = rx_prev_q && !rx_sync;

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            sync_q     <= 2'b11;
            sync_vld_q <= 2'b00;
            rx_prev_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_serial};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rx_prev_q  <= sync_vld_q[1] ? rx_sync : 1'b0;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end

            // Mid-start-bit check rejects glitches shorter than half a bit.
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_sync ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    data_d = {rx_sync, data_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = parity_error(^data_q, rx_sync, PARITY);
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_PUSH;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            // A framing error may be a break; wait for the line to return high
            // so a held-low line produces one word, not a stream of them.
            ST_PUSH: begin
                cnt_d   = '0;
                push    = 1'b1;
                state_d = ferr_q ? ST_WAIT_IDLE : ST_IDLE;
            end

            ST_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pop = in_ready && !fifo_empty;

    always_comb begin
        overflow_d = in_clear_overflow ? 1'b0 : overflow_q;
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overflow_q <= overflow_d;
        end
    end

    rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (in_clk),
        .rst_ni  (in_reset),
        .push_i  (push),
        .data_i  ({ferr_q, perr_q, data_q}),
        .pop_i   (in_ready),
        .data_o  (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (out_count)
    );

    assign out_data       = head_word[DATA_BITS-1:0];
    assign out_parity_err = head_word[DATA_BITS];
    assign out_frame_err  = head_word[DATA_BITS+1];
    assign out_valid      = !fifo_empty;
    assign out_overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Three receivers: u_d with all defaults, u_p with even parity and a short bit
// period, u_f with a 4-entry FIFO and a short bit period. Expected words are
// queued when a frame is sent; per-instance monitors pop and compare on every
// accepted output word. Words are {frame_err, parity_err, data}.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int D_CPB = 640;
    localparam int S_CPB = 16;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_rx, d_ready, d_clr;
    logic [7:0] d_data;
    logic       d_perr, d_ferr, d_valid, d_ovf;
    logic [4:0] d_count;

    logic       p_rx, p_ready, p_clr;
    logic [7:0] p_data;
    logic       p_perr, p_ferr, p_valid, p_ovf;
    logic [4:0] p_count;

    logic       f_rx, f_ready, f_clr;
    logic [7:0] f_data;
    logic       f_perr, f_ferr, f_valid, f_ovf;
    logic [2:0] f_count;

    int vectors;
    int miscompares;

    logic [9:0] q_d [$];
    logic [9:0] q_p [$];
    logic [9:0] q_f [$];

    uart_rx_fifo u_d (
        .in_clk            (clk),
        .in_reset          (rst_n),
        .rx_serial         (d_rx),
        .out_data          (d_data),
        .out_parity_err    (d_perr),
        .out_frame_err     (d_ferr),
        .out_valid         (d_valid),
        .in_ready          (d_ready),
        .out_count         (d_count),
        .out_overflow      (d_ovf),
        .in_clear_overflow (d_clr)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(S_CPB), .PARITY(2)) u_p (
        .in_clk            (clk),
        .in_reset          (rst_n),
        .rx_serial         (p_rx),
        .out_data          (p_data),
        .out_parity_err    (p_perr),
        .out_frame_err     (p_ferr),
        .out_valid         (p_valid),
        .in_ready          (p_ready),
        .out_count         (p_count),
        .out_overflow      (p_ovf),
        .in_clear_overflow (p_clr)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(S_CPB), .FIFO_DEPTH(4)) u_f (
        .in_clk            (clk),
        .in_reset          (rst_n),
        .rx_serial         (f_rx),
        .out_data          (f_data),
        .out_parity_err    (f_perr),
        .out_frame_err     (f_ferr),
        .out_valid         (f_valid),
        .in_ready          (f_ready),
        .out_count         (f_count),
        .out_overflow      (f_ovf),
        .in_clear_overflow (f_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [9:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected word 0x%0h with nothing expected", name, act);
    endtask

    // Monitors: compare each word as it is accepted by the consumer.
    always @(negedge clk) begin
        if (d_valid && d_ready) begin
            if (q_d.size() == 0) unexpected("d_word", {d_ferr, d_perr, d_data});
            else check("d_word", {d_ferr, d_perr, d_data}, q_d.pop_front());
        end
        if (p_valid && p_ready) begin
            if (q_p.size() == 0) unexpected("p_word", {p_ferr, p_perr, p_data});
            else check("p_word", {p_ferr, p_perr, p_data}, q_p.pop_front());
        end
        if (f_valid && f_ready) begin
            if (q_f.size() == 0) unexpected("f_word", {f_ferr, f_perr, f_data});
            else check("f_word", {f_ferr, f_perr, f_data}, q_f.pop_front());
        end
    end

    function automatic int cpb_of(input int which);
        return (which == 0) ? D_CPB : S_CPB;
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0:       return q_d.size();
            1:       return q_p.size();
            default: return q_f.size();
        endcase
    endfunction

    task automatic set_line(input int which, input logic v);
        case (which)
            0:       d_rx = v;
            1:       p_rx = v;
            default: f_rx = v;
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 one bit period later.
    task automatic drive_bit(input int which, input logic v);
        set_line(which, v);
        repeat (cpb_of(which)) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] data,
                              input bit has_par, input logic par_bit,
                              input logic stop_val);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
        if (has_par) drive_bit(which, par_bit);
        drive_bit(which, stop_val);
        drive_bit(which, 1'b1);
    endtask

    task automatic wait_drain(input int which, input int budget);
        int n;
        n = 0;
        while (qsize(which) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (qsize(which) != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_%0d: %0d words still expected after %0d cycles",
                     which, qsize(which), budget);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        d_rx = 1'b1; d_ready = 1'b0; d_clr = 1'b0;
        p_rx = 1'b1; p_ready = 1'b0; p_clr = 1'b0;
        f_rx = 1'b1; f_ready = 1'b0; f_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",    d_valid, 0);
        check("rst_count",    d_count, 0);
        check("rst_overflow", d_ovf,   0);
        check("rst_data",     d_data,  0);
        check("rst_errs",     {d_ferr, d_perr}, 0);
        check("rst_f_count",  f_count, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 200-clock low pulse, shorter than half a 640-clock bit
        d_rx = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        d_rx = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("glitch_valid", d_valid, 0);
        check("glitch_count", d_count, 0);

        // 8N1 defaults: 0x3F
        send_frame(0, 8'h3F, 1'b0, 1'b0, 1'b1);
        check("d_3f_count", d_count, 1);
        check("d_3f_valid", d_valid, 1);
        check("d_3f_head",  {d_ferr, d_perr, d_data}, 10'h03F);
        q_d.push_back(10'h03F);
        d_ready = 1'b1;
        wait_drain(0, 100);
        repeat (2) @(posedge clk);
        #1;
        check("d_empty_pop_count", d_count, 0);

        // Stop bit low -> frame error, then a clean frame
        q_d.push_back(10'h255);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        q_d.push_back(10'h0B7);
        send_frame(0, 8'hB7, 1'b0, 1'b0, 1'b1);
        wait_drain(0, 200);

        // Even parity: 0xA9 has four ones
        p_ready = 1'b1;
        q_p.push_back(10'h1A9);
        send_frame(1, 8'hA9, 1'b1, 1'b1, 1'b1);
        q_p.push_back(10'h0A9);
        send_frame(1, 8'hA9, 1'b1, 1'b0, 1'b1);
        wait_drain(1, 200);

        // Break: line low for 40 bit times yields exactly one framing-error word
        q_p.push_back(10'h200);
        p_rx = 1'b0;
        repeat (40 * S_CPB) @(posedge clk);
        #1;
        p_rx = 1'b1;
        repeat (3 * S_CPB) @(posedge clk);
        #1;
        wait_drain(1, 200);
        check("p_break_count", p_count, 0);

        // Overflow on a 4-entry FIFO
        send_frame(2, 8'h3F, 1'b0, 1'b0, 1'b1);
        send_frame(2, 8'h03, 1'b0, 1'b0, 1'b1);
        send_frame(2, 8'h33, 1'b0, 1'b0, 1'b1);
        send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1);
        check("f_full_ovf_clear", f_ovf, 0);
        send_frame(2, 8'hE4, 1'b0, 1'b0, 1'b1);
        check("f_count_full", f_count, 4);
        check("f_overflow",   f_ovf,   1);
        check("f_head",       f_data,  8'h3F);
        q_f.push_back(10'h03F);
        q_f.push_back(10'h003);
        q_f.push_back(10'h033);
        q_f.push_back(10'h0FF);
        f_ready = 1'b1;
        wait_drain(2, 200);
        repeat (2) @(posedge clk);
        #1;
        check("f_count_drained", f_count, 0);
        check("f_ovf_sticky",    f_ovf,   1);
        f_clr = 1'b1;
        @(posedge clk);
        #1;
        f_clr = 1'b0;
        check("f_ovf_cleared", f_ovf, 0);

        // Reset during data bit 3 (a low bit) of 0xC5, released mid-bit
        fork
            send_frame(0, 8'hC5, 1'b0, 1'b0, 1'b1);
            begin
                repeat (4 * D_CPB + D_CPB / 2) @(posedge clk);
                #1;
                rst_n = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        repeat (2 * D_CPB) @(posedge clk);
        #1;
        check("d_after_reset_count", d_count, 0);
        check("d_after_reset_valid", d_valid, 0);
        q_d.push_back(10'h012);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        wait_drain(0, 200);
        repeat (4) @(posedge clk);
        #1;
        check("d_end_count", d_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 640, giving clocks per bit (115200 baud at 73.728 MHz); legal range 16 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, giving the parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, giving stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, giving receive FIFO entries; must be a power of 2, 2 or more.
REQ-006 SHALL have port in_clk, input, width 1: the single clock; all logic is rising-edge.
REQ-007 SHALL have port in_reset, input, width 1: asynchronous, active-low reset.
REQ-008 SHALL have port rx_serial, input, width 1: asynchronous serial line, idle high.
REQ-009 SHALL have port out_data, output, width DATA_BITS: FIFO head word.
REQ-010 SHALL have port out_parity_err, output, width 1: parity error flag of the head word.
REQ-011 SHALL have port out_frame_err, output, width 1: framing error flag of the head word.
REQ-012 SHALL have port out_valid, output, width 1: FIFO not empty.
REQ-013 SHALL have port in_ready, input, width 1: consumer pops the head when in_ready and out_valid are both high.
REQ-014 SHALL have port out_count, output, width $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-015 SHALL have port out_overflow, output, width 1: sticky overflow flag.
REQ-016 SHALL have port in_clear_overflow, input, width 1: synchronous clear of out_overflow.

Function
REQ-017 SHALL pass rx_serial through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-018 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_IDLE.
REQ-019 IDLE SHALL move to START on a high-to-low transition of the synchronised line.
REQ-020 START SHALL sample the line at CLKS_PER_BIT/2 clocks: low moves to DATA; high is a glitch and returns to IDLE, with nothing pushed.
REQ-021 DATA SHALL sample every CLKS_PER_BIT clocks, DATA_BITS samples, LSB first, then move to PARITY if PARITY != 0, otherwise to STOP.
REQ-022 PARITY SHALL take one sample and set parity_err when the XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode); with PARITY=0, parity_err is constant 0.
REQ-023 STOP SHALL take STOP_BITS samples; any low sample sets frame_err; then move to PUSH.
REQ-024 PUSH SHALL last one cycle and write {frame_err, parity_err, data} to the FIFO; then move to WAIT_IDLE if frame_err is set, otherwise to IDLE.
REQ-025 WAIT_IDLE SHALL stay until the line is high, then go to IDLE; a break condition yields exactly one frame_err word.
REQ-026 Latency: out_valid SHALL rise exactly 2 cycles after the final stop-bit sample when the FIFO was empty.
REQ-027 FIFO SHALL be first-word-fall-through; out_data, out_parity_err and out_frame_err are valid whenever out_valid is high.
REQ-028 A push while full with no pop SHALL drop the new word and set out_overflow; FIFO contents are unchanged.
REQ-029 A push and pop in the same cycle while full SHALL both succeed, with no overflow and out_count unchanged.
REQ-030 A pop while empty SHALL be ignored; out_count never wraps below 0 or above FIFO_DEPTH.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 If in_clear_overflow and an overflow event occur in the same cycle, out_overflow SHALL end that cycle set (set wins).

Reset
REQ-033 While in_reset is low: FSM in IDLE; counters and pointers 0; synchroniser flops 1; out_valid 0; out_count 0; out_overflow 0; out_data 0; error outputs 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release, reception restarts only on a fresh falling edge.

Structure
REQ-035 A shared package uart_pkg SHALL hold the FSM state encoding, parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the default CLKS_PER_BIT.
REQ-036 The FIFO SHALL be a separate sub-module rx_fifo, parameterised by width and depth, with its own push/pop/full/empty/count logic.

Verification
REQ-037 8N1 defaults, send 0x3F -> one word: out_data=0x3F, both error flags 0, out_count=1.
REQ-038 PARITY=2, send 0xA9 with parity bit 1 -> out_parity_err=1; repeat with parity bit 0 -> out_parity_err=0.
REQ-039 Low pulse of 200 clocks on rx_serial -> no push; out_valid stays 0.
REQ-040 FIFO_DEPTH=4, in_ready=0, send 0x3F,0x03,0x33,0xFF,0xE4 -> out_count=4, out_overflow=1; popping yields 0x3F,0x03,0x33,0xFF in order.
REQ-041 Stop bit driven 0 for 0x55, then line high -> word 0x55 with out_frame_err=1; next frame 0xB7 received clean.
REQ-042 in_reset low at the 4th data bit of 0xC5, released, then send 0x12 -> only 0x12 is received.
